// File: rtl/param_bank.sv
// Double-buffered bank of NCH parameter words with edge-triggered per-channel loads,
// bank commit, soft restore to defaults and registered single-word readback.
module param_bank #(
    parameter int                  NCH       = 8,
    parameter int                  DW        = 32,
    parameter bit                  IMMEDIATE = 1'b0,
    parameter logic [NCH*DW-1:0]   DEFAULTS  = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NCH-1:0]    trig,
    input  logic [DW-1:0]     din,
    input  logic              commit,
    input  logic              restore,
    input  logic              rd_req,
    input  logic [3:0]        rd_addr,
    output logic [DW-1:0]     rd_data,
    output logic              rd_valid,
    output logic              rd_err,
    output logic [NCH*DW-1:0] params_out,
    output logic [NCH-1:0]    pending
);

    logic [NCH-1:0] trig_q;
    logic [NCH-1:0] load;
    logic [DW-1:0]  shadow_q [NCH];
    logic [DW-1:0]  shadow_d [NCH];
    logic [DW-1:0]  active_q [NCH];
    logic [DW-1:0]  active_d [NCH];
    logic [NCH-1:0] pending_q, pending_d;
    logic [DW-1:0]  rd_data_q, rd_data_d;
    logic           rd_valid_q, rd_valid_d;
    logic           rd_err_q, rd_err_d;
    logic           in_range;
    logic [DW-1:0]  rd_sel;

    assign load = trig & ~trig_q;

    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        if (restore) begin
            for (int i = 0; i < NCH; i++) begin
                shadow_d[i] = DEFAULTS[i*DW +: DW];
                active_d[i] = DEFAULTS[i*DW +: DW];
            end
            pending_d = '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                // Commit reads the pre-edge shadow, so a coincident load stays pending.
                if (!IMMEDIATE && commit && pending_q[i]) begin
                    active_d[i]  = shadow_q[i];
                    pending_d[i] = 1'b0;
                end
                if (load[i]) begin
                    shadow_d[i] = din;
                    if (IMMEDIATE) begin
                        active_d[i] = din;
                    end else begin
                        pending_d[i] = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        in_range = 1'b0;
        rd_sel   = '0;
        for (int i = 0; i < NCH; i++) begin
            if (rd_addr == 4'(i)) begin
                in_range = 1'b1;
                rd_sel   = active_q[i];
            end
        end
        rd_valid_d = rd_req && in_range;
        rd_err_d   = rd_req && !in_range;
        rd_data_d  = rd_valid_d ? rd_sel : '0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            // All ones so a trig already high when reset releases is not seen as an edge.
            trig_q <= '1;
            for (int i = 0; i < NCH; i++) begin
                shadow_q[i] <= DEFAULTS[i*DW +: DW];
                active_q[i] <= DEFAULTS[i*DW +: DW];
            end
            pending_q  <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
        end else begin
            trig_q <= trig;
            for (int i = 0; i < NCH; i++) begin
                shadow_q[i] <= shadow_d[i];
                active_q[i] <= active_d[i];
            end
            pending_q  <= pending_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            rd_err_q   <= rd_err_d;
        end
    end

    always_comb begin
        params_out = '0;
        for (int i = 0; i < NCH; i++) begin
            params_out[i*DW +: DW] = active_q[i];
        end
    end

    assign pending  = pending_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign rd_err   = rd_err_q;

endmodule

// File: tb/tb_param_bank.sv
// Directed bench for param_bank: a double-buffered instance and an immediate instance
// share clock and reset; expected values are hand-computed constants.
module tb_param_bank;

    localparam int NCH = 8;
    localparam int DW  = 32;
    localparam logic [NCH*DW-1:0] DEFS = {{6{32'h0}}, 32'h3F66_6666, 32'h0};

    logic clk = 1'b0;
    logic reset_n;

    logic [NCH-1:0]    trig0, pending0;
    logic [DW-1:0]     din0, rd_data0;
    logic              commit0, restore0, rd_req0, rd_valid0, rd_err0;
    logic [3:0]        rd_addr0;
    logic [NCH*DW-1:0] params0;

    logic [NCH-1:0]    trig1, pending1;
    logic [DW-1:0]     din1, rd_data1;
    logic              commit1, restore1, rd_req1, rd_valid1, rd_err1;
    logic [3:0]        rd_addr1;
    logic [NCH*DW-1:0] params1;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    param_bank #(.NCH(NCH), .DW(DW), .IMMEDIATE(1'b0), .DEFAULTS(DEFS)) dut0 (
        .clk(clk), .reset_n(reset_n), .trig(trig0), .din(din0), .commit(commit0),
        .restore(restore0), .rd_req(rd_req0), .rd_addr(rd_addr0), .rd_data(rd_data0),
        .rd_valid(rd_valid0), .rd_err(rd_err0), .params_out(params0), .pending(pending0)
    );

    param_bank #(.NCH(NCH), .DW(DW), .IMMEDIATE(1'b1), .DEFAULTS(DEFS)) dut1 (
        .clk(clk), .reset_n(reset_n), .trig(trig1), .din(din1), .commit(commit1),
        .restore(restore1), .rd_req(rd_req1), .rd_addr(rd_addr1), .rd_data(rd_data1),
        .rd_valid(rd_valid1), .rd_err(rd_err1), .params_out(params1), .pending(pending1)
    );

    function automatic logic [DW-1:0] ch(input logic [NCH*DW-1:0] p, input int i);
        return p[i*DW +: DW];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [NCH*DW-1:0] obs, input logic [NCH*DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        trig0 = 8'h08; din0 = '0; commit0 = 0; restore0 = 0; rd_req0 = 0; rd_addr0 = '0;
        trig1 = '0;    din1 = '0; commit1 = 0; restore1 = 0; rd_req1 = 0; rd_addr1 = '0;
        step(); step();
        chk("reset_ch1", ch(params0, 1), 32'h3F66_6666);
        chk("reset_pending", pending0, 8'h00);
        chk("reset_rd_valid", rd_valid0, 1'b0);
        chk("reset_rd_err", rd_err0, 1'b0);
        chk("reset_rd_data", rd_data0, 32'h0);

        // trig[3] held high across reset release: no load
        reset_n = 1'b1;
        step();
        chk("trig_through_reset_pending", pending0, 8'h00);
        trig0 = 8'h00;
        step();
        chk("trig_through_reset_pending2", pending0, 8'h00);

        // Load ch4 then commit
        din0 = 32'h42A0_0000; trig0 = 8'h10;
        step();
        chk("load4_pending", pending0, 8'h10);
        chk("load4_ch4_unchanged", ch(params0, 4), 32'h0);
        trig0 = 8'h00; commit0 = 1'b1;
        step();
        commit0 = 1'b0;
        chk("commit4_ch4", ch(params0, 4), 32'h42A0_0000);
        chk("commit4_pending", pending0, 8'h00);

        // trig[2] held 5 cycles: only the first cycle loads
        trig0 = 8'h04; din0 = 32'h7;
        step();
        chk("hold2_pending", pending0, 8'h04);
        din0 = 32'h9;
        repeat (4) step();
        trig0 = 8'h00; commit0 = 1'b1;
        step();
        commit0 = 1'b0;
        chk("hold2_ch2_single_load", ch(params0, 2), 32'h7);
        chk("hold2_pending_clear", pending0, 8'h00);

        // Load ch0=5, then load ch0=1 coincident with commit
        din0 = 32'h5; trig0 = 8'h01;
        step();
        trig0 = 8'h00;
        step();
        chk("ch0_pending", pending0, 8'h01);
        din0 = 32'h1; trig0 = 8'h01; commit0 = 1'b1;
        step();
        trig0 = 8'h00;
        chk("coincide_ch0_active", ch(params0, 0), 32'h5);
        chk("coincide_ch0_pending", pending0, 8'h01);
        step();
        commit0 = 1'b0;
        chk("coincide_ch0_shadow", ch(params0, 0), 32'h1);
        chk("coincide_pending_clear", pending0, 8'h00);

        // Readback: out of range, then in range, then idle
        rd_req0 = 1'b1; rd_addr0 = 4'd9;
        step();
        chk("rd9_err", rd_err0, 1'b1);
        chk("rd9_valid", rd_valid0, 1'b0);
        chk("rd9_data", rd_data0, 32'h0);
        rd_addr0 = 4'd1;
        step();
        chk("rd1_valid", rd_valid0, 1'b1);
        chk("rd1_err", rd_err0, 1'b0);
        chk("rd1_data", rd_data0, 32'h3F66_6666);
        rd_req0 = 1'b0;
        step();
        chk("rd_idle_valid", rd_valid0, 1'b0);
        chk("rd_idle_err", rd_err0, 1'b0);

        // Readback coincident with commit to the same channel sees pre-edge value
        din0 = 32'h11; trig0 = 8'h10;
        step();
        trig0 = 8'h00; rd_req0 = 1'b1; rd_addr0 = 4'd4; commit0 = 1'b1;
        step();
        rd_req0 = 1'b0; commit0 = 1'b0;
        chk("rd_commit_pre_edge", rd_data0, 32'h42A0_0000);
        chk("rd_commit_ch4_new", ch(params0, 4), 32'h11);

        // Restore beats a coincident load and commit
        din0 = 32'hAB; trig0 = 8'h40;
        step();
        trig0 = 8'h00; din0 = 32'hCD;
        step();
        trig0 = 8'h40; commit0 = 1'b1; restore0 = 1'b1;
        step();
        trig0 = 8'h00; commit0 = 1'b0; restore0 = 1'b0;
        chk("restore_params", params0, DEFS);
        chk("restore_pending", pending0, 8'h00);
        commit0 = 1'b1;
        step();
        commit0 = 1'b0;
        chk("restore_then_commit_params", params0, DEFS);

        // Reset wins over a coincident load
        din0 = 32'h55; trig0 = 8'h20; reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        chk("reset_over_load_pending", pending0, 8'h00);
        chk("reset_over_load_ch5", ch(params0, 5), 32'h0);
        trig0 = 8'h00;

        // Immediate instance
        din1 = 32'h3E71_4120; trig1 = 8'h20;
        step();
        trig1 = 8'h00;
        chk("imm_ch5", ch(params1, 5), 32'h3E71_4120);
        chk("imm_pending", pending1, 8'h00);
        commit1 = 1'b1;
        step();
        commit1 = 1'b0;
        chk("imm_commit_noop", ch(params1, 5), 32'h3E71_4120);
        restore1 = 1'b1;
        step();
        restore1 = 1'b0;
        chk("imm_restore", params1, DEFS);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/param_bank.md
PARAM_BANK -- requirements
Module: param_bank

Interface
REQ-001 SHALL have parameter NCH, default 8: number of parameter channels, range 1..16.
REQ-002 SHALL have parameter DW, default 32: width of each parameter word.
REQ-003 SHALL have parameter IMMEDIATE, default 0: 1 applies loads to the active bank directly; 0 double-buffers until commit.
REQ-004 SHALL have parameter DEFAULTS, default all zeros: NCH*DW flat vector; channel i default at [i*DW +: DW].
REQ-005 SHALL have port clk, input, 1: single clock, rising edge; all ports in this domain.
REQ-006 SHALL have port reset_n, input, 1: reset, synchronous and active-low.
REQ-007 SHALL have port trig, input, NCH: per-channel load request, rising-edge sensitive.
REQ-008 SHALL have port din, input, DW: load data, sampled on a detected trig edge.
REQ-009 SHALL have port commit, input, 1: copies shadow bank to active bank.
REQ-010 SHALL have port restore, input, 1: soft return of both banks to DEFAULTS.
REQ-011 SHALL have port rd_req, input, 1: readback request.
REQ-012 SHALL have port rd_addr, input, 4: readback channel index.
REQ-013 SHALL have port rd_data, output, DW: readback word.
REQ-014 SHALL have port rd_valid, output, 1: one-cycle strobe qualifying rd_data.
REQ-015 SHALL have port rd_err, output, 1: one-cycle strobe for an out-of-range rd_addr.
REQ-016 SHALL have port params_out, output, NCH*DW: active bank, channel i at [i*DW +: DW].
REQ-017 SHALL have port pending, output, NCH: bit i set while shadow[i] holds an uncommitted load.

Function
REQ-018 SHALL register trig into trig_q every cycle; channel i load edge = trig[i] & ~trig_q[i].
REQ-019 SHALL write din into shadow[i] on the clock edge where a load edge is present, for every such i simultaneously; multiple channels loading in one cycle all take the same din.
REQ-020 SHALL, with IMMEDIATE=0, set pending[i] on a load; active[i] and params_out SHALL be unchanged until commit.
REQ-021 SHALL, with IMMEDIATE=1, write active[i] on the same edge as shadow[i]; pending SHALL stay 0; commit SHALL have no effect.
REQ-022 SHALL, on an edge with commit=1 (IMMEDIATE=0), copy every shadow[i] with pending[i]=1 into active[i] and clear that pending bit; channels not pending SHALL be untouched.
REQ-023 SHALL, when load and commit coincide on channel i, commit the pre-edge shadow[i] into active[i], write din into shadow[i], and leave pending[i]=1.
REQ-024 SHALL drive params_out directly from active registers: a commit is visible on params_out the cycle after the commit edge.
REQ-025 SHALL, on an edge with rd_req=1 and rd_addr<NCH, register rd_data=active[rd_addr] and set rd_valid=1 for the next cycle only.
REQ-026 SHALL, when rd_req=1 and rd_addr>=NCH, set rd_data=0, rd_valid=0 and rd_err=1 for the next cycle only.
REQ-027 SHALL read pre-edge active contents when rd_req coincides with a commit or load to the same channel.
REQ-028 SHALL give restore=1 priority over load and commit: shadow and active to DEFAULTS, pending to 0; trig_q SHALL still update normally.
REQ-029 SHALL hold rd_valid=0 and rd_err=0 whenever rd_req was 0 on the previous edge.

Reset
REQ-030 SHALL, on an edge with reset_n=0, set shadow and active to DEFAULTS, pending=0, rd_data=0, rd_valid=0 and rd_err=0.
REQ-031 SHALL set trig_q to all ones on a reset edge, so a trig held high through reset produces no load.
REQ-032 SHALL give reset_n=0 priority over restore, load, commit and rd_req, including mid-operation.

Verification
REQ-033 SHALL cover (NCH=8, DW=32, IMMEDIATE=0, DEFAULTS ch1=32'h3F66_6666): after reset, params_out ch1=32'h3F66_6666, pending=0.
REQ-034 SHALL cover: din=32'h42A0_0000, trig[4] pulse -> pending=8'h10 and ch4 unchanged; commit pulse -> ch4=32'h42A0_0000 the next cycle, pending=0.
REQ-035 SHALL cover: trig[2] held high for 5 cycles -> exactly one load; trig[3] held high across a reset release -> no load on ch3.
REQ-036 SHALL cover: load ch0=32'h1 and commit in the same cycle (shadow ch0 previously 32'h5, pending) -> active=32'h5, shadow=32'h1, pending[0]=1.
REQ-037 SHALL cover: rd_req with rd_addr=9 -> rd_err=1 and rd_valid=0 for one cycle; rd_addr=1 -> rd_valid=1 with rd_data=active[1].
REQ-038 SHALL cover: IMMEDIATE=1, trig[5] with din=32'h3E71_4120 -> ch5 on params_out the next cycle; restore -> all channels equal DEFAULTS.
